nn_param_loader: RTL

Upstream control stage for the `NN` XOR network. It loads the nine FP32 network parameters over a valid/ready word stream into shadow registers and commits them atomically to the network's weight/bias inputs. It then accepts `(A, B)` input vectors one at a time, holds each stable on the network inputs for a fixed settle window, and pulses `vec_done` when `XOR_output` may be sampled.

---
 rtl/nn_param_loader_if.sv | 24 ++
 rtl/nn_param_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/nn_param_loader_if.sv
// rtl/nn_param_loader_if.sv - parameter word stream and input vector stream for nn_param_loader
interface nn_param_loader_if #(
    parameter int data_width = 32
);
    logic                  cfg_start;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [data_width-1:0] cfg_data;
    logic                  cfg_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] in_a;
    logic [data_width-1:0] in_b;

    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_a, in_b,
        input  cfg_ready, in_ready
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_a, in_b,
        output cfg_ready, in_ready
    );
endinterface

// File: rtl/nn_param_loader.sv
// rtl/nn_param_loader.sv - loads nine NN parameters into shadow regs, commits atomically, holds input vectors for a settle window
module nn_param_loader #(
    parameter int exp_width     = 8,
    parameter int mant_width    = 24,
    parameter int data_width    = exp_width + mant_width,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    nn_param_loader_if.slave      bus,
    output logic [data_width-1:0] w11,
    output logic [data_width-1:0] w12,
    output logic [data_width-1:0] w21,
    output logic [data_width-1:0] w22,
    output logic [data_width-1:0] b1,
    output logic [data_width-1:0] b2,
    output logic [data_width-1:0] w31,
    output logic [data_width-1:0] w32,
    output logic [data_width-1:0] b3,
    output logic [data_width-1:0] A,
    output logic [data_width-1:0] B,
    output logic                  params_valid,
    output logic                  vec_done,
    output logic                  load_error
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;
    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    logic [1:0]            state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [data_width-1:0] shadow_q [0:8];
    logic [data_width-1:0] shadow_d [0:8];
    logic [data_width-1:0] params_q [0:8];
    logic [data_width-1:0] params_d [0:8];
    logic [data_width-1:0] a_q, a_d, b_q, b_d;
    logic                  pv_q, pv_d, err_q, err_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        params_d = params_q;
        a_d      = a_q;
        b_d      = b_q;
        pv_d     = pv_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.cfg_valid) begin
                    for (int i = 0; i < 9; i++) begin
                        if (idx_q == 4'(i)) shadow_d[i] = bus.cfg_data;
                    end
                    // The 9th word commits regardless of cfg_last; an early last aborts.
                    if (idx_q == 4'd8) begin
                        params_d = shadow_d;
                        pv_d     = 1'b1;
                        state_d  = ST_READY;
                    end else if (bus.cfg_last) begin
                        err_d   = 1'b1;
                        pv_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_READY: begin
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end else if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_READY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pv_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= '0;
                params_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pv_q     <= pv_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            params_q <= params_d;
        end
    end

    assign bus.cfg_ready = (state_q == ST_LOAD);
    assign bus.in_ready  = (state_q == ST_READY);
    assign vec_done      = (state_q == ST_SETTLE) && (cnt_q == '0);
    assign params_valid  = pv_q;
    assign load_error    = err_q;
    assign A             = a_q;
    assign B             = b_q;
    assign w11 = params_q[0];
    assign w12 = params_q[1];
    assign w21 = params_q[2];
    assign w22 = params_q[3];
    assign b1  = params_q[4];
    assign b2  = params_q[5];
    assign w31 = params_q[6];
    assign w32 = params_q[7];
    assign b3  = params_q[8];
endmodule
